// File: rtl/huff_addr_gen.sv
// huff_addr_gen: address sequencer for the Huffman encoder's symbol and
// frequency memories. Issues cfg_len addresses from cfg_base, advancing by
// the stride, under an addr_vld/en handshake. One-shot or continuous wrap.
//
// Build option: HUFF_ADDR_GEN_STRIDE_EN
//   defined     -> cfg_stride is latched on start and used as the increment
//   not defined -> increment is fixed at 1, cfg_stride is ignored
//
// state | meaning
// IDLE  | waiting for start; addr holds its last value
// RUN   | addr valid, beats transfer when en is high
// DONE  | one-shot run finished; done pulses for this single cycle

module huff_addr_gen #(
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic              en,
    input  logic [ADDR_W-1:0] cfg_base,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic [ADDR_W-1:0] cfg_stride,
    input  logic              cfg_wrap,
    output logic [ADDR_W-1:0] addr,
    output logic              addr_vld,
    output logic              last,
    output logic              pass_done,
    output logic              done,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  cnt_q;
    logic              wrap_q;
    logic              pass_done_q;
    logic [ADDR_W-1:0] step;

    logic beat;
    logic is_last;
    logic start_ok;

    // A zero-length start goes straight to DONE without touching the datapath.
    assign start_ok = (state == IDLE) && start && (cfg_len != '0);
    assign beat     = (state == RUN) && en;
    assign is_last  = (state == RUN) && (cnt_q == (len_q - LEN_W'(1)));

`ifdef HUFF_ADDR_GEN_STRIDE_EN
    logic [ADDR_W-1:0] stride_q;

    // Stride register, captured together with the rest of the run config.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stride_q <= '0;
        end else if (!stop && start_ok) begin
            stride_q <= cfg_stride;
        end
    end

    assign step = stride_q;
`else
    logic unused_stride;

    assign unused_stride = ^cfg_stride;
    assign step          = ADDR_W'(1);
`endif

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; stop overrides everything and lands in IDLE.
    always_comb begin
        state_nxt = state;
        if (stop) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = (cfg_len == '0) ? DONE : RUN;
                    end
                end
                RUN: begin
                    if (beat && is_last && !wrap_q) begin
                        state_nxt = DONE;
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Config latch, address and beat counter; all hold while stalled or stopped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
            base_q <= '0;
            len_q  <= '0;
            cnt_q  <= '0;
            wrap_q <= 1'b0;
        end else if (!stop) begin
            if (start_ok) begin
                base_q <= cfg_base;
                len_q  <= cfg_len;
                wrap_q <= cfg_wrap;
                addr_q <= cfg_base;
                cnt_q  <= '0;
            end else if (beat) begin
                if (is_last) begin
                    if (wrap_q) begin
                        addr_q <= base_q;
                        cnt_q  <= '0;
                    end
                end else begin
                    addr_q <= addr_q + step;
                    cnt_q  <= cnt_q + LEN_W'(1);
                end
            end
        end
    end

    // End-of-pass pulse, one cycle after the final beat transfers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pass_done_q <= 1'b0;
        end else begin
            pass_done_q <= !stop && beat && is_last;
        end
    end

    // Outputs decoded from the state and datapath registers.
    always_comb begin
        addr      = addr_q;
        addr_vld  = (state == RUN);
        last      = is_last;
        pass_done = pass_done_q;
        done      = (state == DONE);
        busy      = (state != IDLE);
    end

endmodule

// File: tb/tb_huff_addr_gen.sv
// Directed testbench for huff_addr_gen: hand-computed address sequences,
// stall, modulo wrap, continuous mode, stop, reset, ignored restart,
// zero length and the stride build option.

module tb_huff_addr_gen;

    localparam int ADDR_W = 8;
    localparam int LEN_W  = 9;

    logic              clk;
    logic              rst;
    logic              start;
    logic              stop;
    logic              en;
    logic [ADDR_W-1:0] cfg_base;
    logic [LEN_W-1:0]  cfg_len;
    logic [ADDR_W-1:0] cfg_stride;
    logic              cfg_wrap;
    logic [ADDR_W-1:0] addr;
    logic              addr_vld;
    logic              last;
    logic              pass_done;
    logic              done;
    logic              busy;

    int n_vec;
    int n_err;
    int pd_cnt;
    int done_cnt;

    huff_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .en         (en),
        .cfg_base   (cfg_base),
        .cfg_len    (cfg_len),
        .cfg_stride (cfg_stride),
        .cfg_wrap   (cfg_wrap),
        .addr       (addr),
        .addr_vld   (addr_vld),
        .last       (last),
        .pass_done  (pass_done),
        .done       (done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // addr, addr_vld, last, pass_done, done, busy packed into one word
    task automatic chk_all(input string tag, input logic [7:0] a, input logic v,
                           input logic l, input logic pd, input logic d, input logic b);
        chk(tag, {addr, addr_vld, last, pass_done, done, busy}, {a, v, l, pd, d, b});
    endtask

    task automatic launch(input logic [7:0] base, input logic [8:0] len,
                          input logic [7:0] stride, input logic wrap);
        cfg_base   = base;
        cfg_len    = len;
        cfg_stride = stride;
        cfg_wrap   = wrap;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_a [4];
        n_vec = 0;
        n_err = 0;
        rst = 1'b1; start = 1'b0; stop = 1'b0; en = 1'b1;
        cfg_base = '0; cfg_len = '0; cfg_stride = '0; cfg_wrap = 1'b0;
        tick();
        chk_all("reset", 8'h00, 0, 0, 0, 0, 0);
        rst = 1'b0;
        tick();

        // one-shot, base 0x10 len 3
        launch(8'h10, 9'd3, 8'd1, 1'b0);
        chk_all("run1_b0", 8'h10, 1, 0, 0, 0, 1);
        tick(); chk_all("run1_b1", 8'h11, 1, 0, 0, 0, 1);
        tick(); chk_all("run1_b2", 8'h12, 1, 1, 0, 0, 1);
        tick(); chk_all("run1_done", 8'h12, 0, 0, 1, 1, 1);
        tick(); chk_all("run1_idle", 8'h12, 0, 0, 0, 0, 0);

        // same run with two stall cycles at 0x11
        launch(8'h10, 9'd3, 8'd1, 1'b0);
        chk_all("stall_b0", 8'h10, 1, 0, 0, 0, 1);
        tick(); chk_all("stall_b1", 8'h11, 1, 0, 0, 0, 1);
        en = 1'b0;
        tick(); chk_all("stall_h1", 8'h11, 1, 0, 0, 0, 1);
        tick(); chk_all("stall_h2", 8'h11, 1, 0, 0, 0, 1);
        en = 1'b1;
        tick(); chk_all("stall_b2", 8'h12, 1, 1, 0, 0, 1);
        tick(); chk_all("stall_done", 8'h12, 0, 0, 1, 1, 1);
        tick();

        // modulo wrap of the address
        exp_a = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        launch(8'hFE, 9'd4, 8'd1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_all($sformatf("mod_b%0d", i), exp_a[i], 1, (i == 3), 0, 0, 1);
            tick();
        end
        chk_all("mod_done", 8'h01, 0, 0, 1, 1, 1);
        tick();

        // continuous mode, base 0x05 len 2
        pd_cnt = 0; done_cnt = 0;
        launch(8'h05, 9'd2, 8'd1, 1'b1);
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("wrap_a%0d", i), {addr, addr_vld}, {(i % 2 == 0) ? 8'h05 : 8'h06, 1'b1});
            pd_cnt += int'(pass_done);
            done_cnt += int'(done);
            tick();
        end
        chk("wrap_a6", {addr, addr_vld}, {8'h05, 1'b1});
        pd_cnt += int'(pass_done);
        done_cnt += int'(done);
        chk("wrap_pd_cnt", pd_cnt, 3);
        chk("wrap_done_cnt", done_cnt, 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("wrap_stop", 8'h05, 0, 0, 0, 0, 0);
        tick();

        // stop at 0x11 of a len 8 run
        launch(8'h10, 9'd8, 8'd1, 1'b0);
        tick(); chk_all("stop_b1", 8'h11, 1, 0, 0, 0, 1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk_all("stop_idle", 8'h11, 0, 0, 0, 0, 0);
        tick(); chk_all("stop_nodone", 8'h11, 0, 0, 0, 0, 0);

        // start while running is ignored
        launch(8'h10, 9'd3, 8'd1, 1'b0);
        tick(); chk_all("rst_run_b1", 8'h11, 1, 0, 0, 0, 1);
        cfg_base = 8'h80; cfg_len = 9'd5; start = 1'b1;
        tick(); chk_all("restart_ign", 8'h12, 1, 1, 0, 0, 1);
        start = 1'b0;
        tick(); chk_all("restart_done", 8'h12, 0, 0, 1, 1, 1);
        tick();

        // asynchronous reset mid-run, then start on the first edge
        launch(8'h40, 9'd8, 8'd1, 1'b0);
        tick(); chk_all("arst_b1", 8'h41, 1, 0, 0, 0, 1);
        #2 rst = 1'b1;
        #1 chk_all("arst_now", 8'h00, 0, 0, 0, 0, 0);
        rst = 1'b0;
        launch(8'h30, 9'd1, 8'd1, 1'b0);
        chk_all("arst_start", 8'h30, 1, 1, 0, 0, 1);
        tick(); chk_all("arst_done", 8'h30, 0, 0, 1, 1, 1);
        tick();

        // zero-length run
        launch(8'h22, 9'd0, 8'd1, 1'b0);
        chk_all("len0_done", 8'h30, 0, 0, 0, 1, 1);
        tick(); chk_all("len0_idle", 8'h30, 0, 0, 0, 0, 0);

        // stride option
`ifdef HUFF_ADDR_GEN_STRIDE_EN
        exp_a = '{8'h00, 8'h04, 8'h08, 8'h0C};
`else
        exp_a = '{8'h00, 8'h01, 8'h02, 8'h03};
`endif
        launch(8'h00, 9'd4, 8'd4, 1'b0);
        for (int i = 0; i < 4; i++) begin
            chk_all($sformatf("stride_b%0d", i), exp_a[i], 1, (i == 3), 0, 0, 1);
            tick();
        end
        chk_all("stride_done", exp_a[3], 0, 0, 1, 1, 1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
